// File: rtl/encoder8_3.sv
// Registered 8-to-3 priority encoder with a valid flag.
// Direction of priority is set by MSB_PRIORITY (1: highest index wins, 0: lowest index wins).
module encoder8_3 #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
);

    logic [2:0] idx_s;
    logic       any_s;
    logic [2:0] out_r;
    logic       valid_r;

    // Winner search: scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        logic [2:0] pos_s;
        idx_s = 3'd0;
        any_s = |in;
        pos_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (MSB_PRIORITY) begin
                pos_s = 3'(i);
            end else begin
                pos_s = 3'(7 - i);
            end
            if (in[pos_s]) begin
                idx_s = pos_s;
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Output registers with synchronous active-low reset; all-zero input also clears the index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_r   <= 3'd0;
            valid_r <= 1'b0;
        end else begin
            out_r   <= idx_s;
            valid_r <= any_s;
        end
    end

    assign out   = out_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_encoder8_3.sv
// Self-checking bench: two encoder instances (MSB and LSB priority) against an arithmetic model,
// plus literal expectations for the directed cases.
module tb_encoder8_3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] out_msb;
    logic       valid_msb;
    logic [2:0] out_lsb;
    logic       valid_lsb;

    int n_checks;
    int n_fail;

    logic [2:0] exp_m;
    logic [2:0] exp_l;
    logic       exp_v;
    logic       model_live;

    encoder8_3 #(.MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in(req), .out(out_msb), .valid(valid_msb)
    );

    encoder8_3 #(.MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in(req), .out(out_lsb), .valid(valid_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // floor(log2(v)) by repeated halving
    function automatic int log2f(input int unsigned v);
        int k;
        k = 0;
        while (v > 32'd1) begin
            v = v >> 1;
            k++;
        end
        return k;
    endfunction

    function automatic int msb_index(input logic [7:0] v);
        int unsigned x;
        x = 32'(v);
        return (x == 32'd0) ? 0 : log2f(x);
    endfunction

    function automatic int lsb_index(input logic [7:0] v);
        int unsigned x;
        x = 32'(v);
        return (x == 32'd0) ? 0 : log2f(x & (~x + 32'd1));
    endfunction

    // Reference model: what each output register must hold after this edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_m <= 3'd0;
            exp_l <= 3'd0;
            exp_v <= 1'b0;
        end else begin
            exp_m <= 3'(msb_index(req));
            exp_l <= 3'(lsb_index(req));
            exp_v <= (req != 8'd0);
        end
        model_live <= 1'b1;
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            n_checks++;
            if (out_msb !== exp_m || valid_msb !== exp_v) begin
                n_fail++;
                $display("FAIL model_msb: got out=%0d valid=%0b, want out=%0d valid=%0b (req was sampled last edge)",
                         out_msb, valid_msb, exp_m, exp_v);
            end
            n_checks++;
            if (out_lsb !== exp_l || valid_lsb !== exp_v) begin
                n_fail++;
                $display("FAIL model_lsb: got out=%0d valid=%0b, want out=%0d valid=%0b",
                         out_lsb, valid_lsb, exp_l, exp_v);
            end
        end
    end

    // Drive one vector for one edge, then check both instances against hand-computed values.
    task automatic apply(input logic [7:0] v, input logic r, input logic [2:0] em,
                         input logic [2:0] el, input logic ev, input string name);
        @(negedge clk);
        req   = v;
        rst_n = r;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_msb !== em || valid_msb !== ev || out_lsb !== el || valid_lsb !== ev) begin
            n_fail++;
            $display("FAIL %s: in=%h got msb=%0d/%0b lsb=%0d/%0b, want msb=%0d lsb=%0d valid=%0b",
                     name, v, out_msb, valid_msb, out_lsb, valid_lsb, em, el, ev);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        model_live = 1'b0;
        rst_n      = 1'b0;
        req        = 8'hFF;

        apply(8'hFF, 1'b0, 3'd0, 3'd0, 1'b0, "reset_edge1");
        apply(8'hFF, 1'b0, 3'd0, 3'd0, 1'b0, "reset_edge2");
        apply(8'hFF, 1'b1, 3'd7, 3'd0, 1'b1, "first_after_reset");

        apply(8'h20, 1'b1, 3'd5, 3'd5, 1'b1, "pre_zero_5");
        apply(8'h00, 1'b1, 3'd0, 3'd0, 1'b0, "all_zero");

        for (int k = 0; k < 8; k++) begin
            logic [7:0] oh;
            oh = 8'(8'd1 << k);
            apply(oh, 1'b1, 3'(k), 3'(k), 1'b1, "one_hot");
        end

        apply(8'b1001_0100, 1'b1, 3'd7, 3'd2, 1'b1, "multi_94");
        apply(8'b0000_0110, 1'b1, 3'd2, 3'd1, 1'b1, "multi_06");
        apply(8'b0111_1111, 1'b1, 3'd6, 3'd0, 1'b1, "multi_7f");
        apply(8'b1000_0000, 1'b1, 3'd7, 3'd7, 1'b1, "bit7");
        apply(8'hFF,        1'b1, 3'd7, 3'd0, 1'b1, "all_ones");
        apply(8'h01,        1'b1, 3'd0, 3'd0, 1'b1, "bit0_valid");

        for (int k = 0; k < 3; k++) begin
            apply(8'h40, 1'b1, 3'd6, 3'd6, 1'b1, "steady_40");
        end
        apply(8'h40, 1'b0, 3'd0, 3'd0, 1'b0, "midstream_reset");
        apply(8'h40, 1'b1, 3'd6, 3'd6, 1'b1, "after_midstream_reset");

        // Random traffic with occasional resets, checked by the model only.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req   = 8'($urandom_range(0, 255));
            rst_n = ($urandom_range(0, 15) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
